// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op and state types plus operand signedness decode for muldiv_unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } mdOp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdState_t;

  // MUL is treated as signed: the low half of the product is the same either way
  function automatic logic is_signed_a(input mdOp_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_signed_b(input mdOp_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - EX-stage handshake between pipeline and muldiv_unit
interface muldiv_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);

  logic                      startE;
  logic [2:0]                funct3E;
  logic [DATA_WIDTH-1:0]     srcAE;
  logic [DATA_WIDTH-1:0]     srcBE;
  logic [REG_ADDR_WIDTH-1:0] rdE;
  logic                      kill;
  logic                      stallReq;
  logic                      done;
  logic [DATA_WIDTH-1:0]     result;
  logic [REG_ADDR_WIDTH-1:0] rdOut;
  logic                      illegalOp;

  modport master (
    output startE, funct3E, srcAE, srcBE, rdE, kill,
    input  stallReq, done, result, rdOut, illegalOp
  );

  modport slave (
    input  startE, funct3E, srcAE, srcBE, rdE, kill,
    output stallReq, done, result, rdOut, illegalOp
  );

endinterface

// File: rtl/muldiv_sign.sv
// rtl/muldiv_sign.sv - conditional two's-complement negate (magnitude on entry, sign fix-up on exit)
module muldiv_sign #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] out
);

  assign out = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; divider compiled in with MULDIV_DIV_EN
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  mdState_t                  state, stateNext;
  logic [CW-1:0]             cnt;
  mdOp_t                     op;
  logic [REG_ADDR_WIDTH-1:0] rdReg;
  logic [DW-1:0]             bMag;
  // {high, low}: product while multiplying, {remainder, quotient} while dividing
  logic [2*DW-1:0]           acc;
  logic                      negLo, negHi, illegal;
  logic [DW-1:0]             resultReg;
  logic [REG_ADDR_WIDTH-1:0] rdOutReg;

  mdOp_t         opIn;
  logic          signA, signB, accept, lastStep, shortOp;
  logic [DW-1:0] aMagIn, bMagIn, loFix, hiFix, hiCarry, finalRes;
  logic [DW:0]   mulSum;
  logic [2*DW-1:0] mulNext;

  assign opIn     = mdOp_t'(bus.funct3E);
  assign signA    = is_signed_a(opIn) & bus.srcAE[DW-1];
  assign signB    = is_signed_b(opIn) & bus.srcBE[DW-1];
  assign accept   = (state == ST_IDLE) & bus.startE & ~bus.kill;
  assign lastStep = (cnt == CW'(DW));

  muldiv_sign #(.WIDTH(DW)) uSignA (.value(bus.srcAE), .negate(signA), .out(aMagIn));
  muldiv_sign #(.WIDTH(DW)) uSignB (.value(bus.srcBE), .negate(signB), .out(bMagIn));

  assign mulSum  = {1'b0, acc[2*DW-1:DW]} + {1'b0, (acc[0] ? bMag : {DW{1'b0}})};
  assign mulNext = {mulSum, acc[DW-1:1]};

`ifdef MULDIV_DIV_EN
  logic            divZero, divOvf;
  logic [DW:0]     divTrial;
  logic [2*DW-1:0] divNext;

  assign divZero  = (bus.srcBE == {DW{1'b0}});
  assign divOvf   = ((opIn == MD_DIV) || (opIn == MD_REM)) &&
                    (bus.srcAE == {1'b1, {(DW-1){1'b0}}}) && (bus.srcBE == {DW{1'b1}});
  assign shortOp  = opIn[2] & (divZero | divOvf);
  assign divTrial = {acc[2*DW-1:DW], acc[DW-1]} - {1'b0, bMag};
  assign divNext  = divTrial[DW] ? {acc[2*DW-2:0], 1'b0}
                                 : {divTrial[DW-1:0], acc[DW-2:0], 1'b1};
`else
  assign shortOp  = opIn[2];
`endif

  // Sign fix-up: the high half of a negated product only takes the carry when the low half is zero
  muldiv_sign #(.WIDTH(DW)) uFixLo (.value(acc[DW-1:0]), .negate(negLo), .out(loFix));
  assign hiCarry  = {{(DW-1){1'b0}}, (op[2] ? 1'b1 : (acc[DW-1:0] == {DW{1'b0}}))};
  assign hiFix    = negHi ? (~acc[2*DW-1:DW] + hiCarry) : acc[2*DW-1:DW];
  assign finalRes = ((op == MD_MUL) || (op == MD_DIV) || (op == MD_DIVU)) ? loFix : hiFix;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= stateNext;
  end

  // Next state; short ops run only the final step of an iterating state (counter preset)
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef MULDIV_DIV_EN
          stateNext = opIn[2] ? ST_DIV : ST_MUL;
`else
          stateNext = ST_MUL;
`endif
        end
      end
      ST_MUL:  if (lastStep) stateNext = ST_DONE;
`ifdef MULDIV_DIV_EN
      ST_DIV:  if (lastStep) stateNext = ST_DONE;
`endif
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
    if (bus.kill) stateNext = ST_IDLE;
  end

  // Operand latch, iteration datapath and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      op        <= MD_MUL;
      rdReg     <= '0;
      bMag      <= '0;
      acc       <= '0;
      negLo     <= 1'b0;
      negHi     <= 1'b0;
      illegal   <= 1'b0;
      resultReg <= '0;
      rdOutReg  <= '0;
    end else if (bus.kill) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op      <= opIn;
            rdReg   <= bus.rdE;
            bMag    <= bMagIn;
            illegal <= 1'b0;
            cnt     <= '0;
            acc     <= {{DW{1'b0}}, aMagIn};
            negLo   <= signA ^ signB;
            negHi   <= opIn[2] ? signA : (signA ^ signB);
            if (shortOp) begin
              negLo <= 1'b0;
              negHi <= 1'b0;
              cnt   <= CW'(DW);
`ifdef MULDIV_DIV_EN
              acc   <= divZero ? {bus.srcAE, {DW{1'b1}}} : {{DW{1'b0}}, bus.srcAE};
`else
              acc     <= '0;
              illegal <= 1'b1;
`endif
            end
          end
        end
        ST_MUL: begin
          if (lastStep) begin
            resultReg <= finalRes;
            rdOutReg  <= rdReg;
            cnt       <= '0;
          end else begin
            acc <= mulNext;
            cnt <= cnt + CW'(1);
          end
        end
`ifdef MULDIV_DIV_EN
        ST_DIV: begin
          if (lastStep) begin
            resultReg <= finalRes;
            rdOutReg  <= rdReg;
            cnt       <= '0;
          end else begin
            acc <= divNext;
            cnt <= cnt + CW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.stallReq  = ((state == ST_IDLE) & bus.startE) | (state == ST_MUL) | (state == ST_DIV);
  assign bus.done      = (state == ST_DONE);
  assign bus.illegalOp = (state == ST_DONE) & illegal;
  assign bus.result    = resultReg;
  assign bus.rdOut     = rdOutReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();
  muldiv_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e, input int lat);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.e = e; v.lat = lat;
    return v;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a); sb = $signed(b);
    ua = {32'd0, a}; ub = {32'd0, b};
    if (f3[2] && !DIV_EN) return 32'd0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) begin
      if (!DIV_EN) return 2;
      if (b == 0) return 2;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    end
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Drives one op from an IDLE cycle and measures it; returns just after the edge leaving DONE
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output logic [31:0] res, output logic [4:0] rdo, output int lat,
                        output logic ill, output logic stallBad);
    bus.startE = 1'b1; bus.funct3E = f3; bus.srcAE = a; bus.srcBE = b; bus.rdE = rd;
    lat = -1; stallBad = 1'b0; res = '0; rdo = '0; ill = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = c; res = bus.result; rdo = bus.rdOut; ill = bus.illegalOp;
        if (bus.stallReq !== 1'b0) stallBad = 1'b1;
        break;
      end
      if (bus.stallReq !== 1'b1) stallBad = 1'b1;
    end
    @(posedge clk); #1;
    bus.startE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.startE = 1'b0; bus.kill = 1'b0; bus.funct3E = '0; bus.srcAE = '0; bus.srcBE = '0; bus.rdE = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.stallReq !== 1'b0) begin bad++; $display("FAIL reset_stallReq got=%b want=0", bus.stallReq); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.illegalOp !== 1'b0) begin bad++; $display("FAIL reset_illegalOp got=%b want=0", bus.illegalOp); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++; if (bus.rdOut !== 5'd0) begin bad++; $display("FAIL reset_rdOut got=%0d want=0", bus.rdOut); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[$];
    logic [31:0] res; logic [4:0] rdo; int lat; logic ill, sb;
    int dl;
    dl = DIV_EN ? 34 : 2;
    v.push_back(mk(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34));
    v.push_back(mk(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34));
    v.push_back(mk(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34));
    v.push_back(mk(3'd4, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'd0, dl));
    v.push_back(mk(3'd6, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'd0, dl));
    v.push_back(mk(3'd5, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, dl));
    v.push_back(mk(3'd7, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0, dl));
    v.push_back(mk(3'd5, 32'h1234, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 2));
    v.push_back(mk(3'd6, 32'h1234, 32'd0, DIV_EN ? 32'h0000_1234 : 32'd0, 2));
    v.push_back(mk(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'd0, 2));
    v.push_back(mk(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2));
    foreach (v[i]) begin
      run_op(v[i].f3, v[i].a, v[i].b, 5'(i + 1), res, rdo, lat, ill, sb);
      total++; if (res !== v[i].e) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, v[i].e); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, v[i].lat); end
      total++; if (rdo !== 5'(i + 1)) begin bad++; $display("FAIL dir%0d_rdOut got=%0d want=%0d", i, rdo, i + 1); end
      total++; if (ill !== (!DIV_EN && v[i].f3[2])) begin bad++; $display("FAIL dir%0d_illegal got=%b want=%b", i, ill, (!DIV_EN && v[i].f3[2])); end
      total++; if (sb !== 1'b0) begin bad++; $display("FAIL dir%0d_stallReq got=bad want=high until done", i); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, e; logic [2:0] f3; logic [4:0] rd, rdo; int lat, el; logic ill, sb;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand(); rd = 5'($urandom);
      e = ref_result(f3, a, b); el = ref_latency(f3, a, b);
      run_op(f3, a, b, rd, res, rdo, lat, ill, sb);
      total++; if (res !== e) begin bad++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h got=%h want=%h", i, f3, a, b, res, e); end
      total++; if (lat !== el) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, el); end
      total++; if (rdo !== rd) begin bad++; $display("FAIL rnd%0d_rdOut got=%0d want=%0d", i, rdo, rd); end
      total++; if (ill !== (!DIV_EN && f3[2])) begin bad++; $display("FAIL rnd%0d_illegal got=%b want=%b", i, ill, (!DIV_EN && f3[2])); end
      total++; if (sb !== 1'b0) begin bad++; $display("FAIL rnd%0d_stallReq got=bad want=high until done", i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic [4:0] rdo; int lat; logic ill, sb;
    run_op(3'd0, 32'd6, 32'd7, 5'd4, res, rdo, lat, ill, sb);
    total++; if (res !== 32'd42) begin bad++; $display("FAIL b2b_first_result got=%h want=%h", res, 32'd42); end
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd5, res, rdo, lat, ill, sb);
    total++; if (res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_second_result got=%h want=ffffffff", res); end
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_second_latency got=%0d want=34", lat); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL hold%0d_done got=%b want=0", c, bus.done); end
      total++; if (bus.illegalOp !== 1'b0) begin bad++; $display("FAIL hold%0d_illegalOp got=%b want=0", c, bus.illegalOp); end
      total++; if (bus.result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL hold%0d_result got=%h want=ffffffff", c, bus.result); end
      total++; if (bus.rdOut !== 5'd5) begin bad++; $display("FAIL hold%0d_rdOut got=%0d want=5", c, bus.rdOut); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_kill();
    logic [31:0] res; logic [4:0] rdo; int lat; logic ill, sb, sawDone;
    run_op(3'd0, 32'd7, 32'd6, 5'd3, res, rdo, lat, ill, sb);
    total++; if (res !== 32'd42) begin bad++; $display("FAIL kill_pre_result got=%h want=%h", res, 32'd42); end
    bus.startE = 1'b1; bus.funct3E = 3'd0; bus.srcAE = $urandom; bus.srcBE = $urandom; bus.rdE = 5'd17;
    sawDone = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) sawDone = 1'b1;
      if (c == 10) bus.kill = 1'b1;
    end
    @(posedge clk); #1;
    bus.kill = 1'b0; bus.startE = 1'b0;
    @(negedge clk);
    total++; if (sawDone !== 1'b0) begin bad++; $display("FAIL kill_early_done got=1 want=0"); end
    total++; if (bus.stallReq !== 1'b0) begin bad++; $display("FAIL kill_idle_stallReq got=%b want=0", bus.stallReq); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL kill_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 32'd42) begin bad++; $display("FAIL kill_result_kept got=%h want=%h", bus.result, 32'd42); end
    total++; if (bus.rdOut !== 5'd3) begin bad++; $display("FAIL kill_rdOut_kept got=%0d want=3", bus.rdOut); end
    @(posedge clk); #1;
    bus.startE = 1'b1; bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.startE = 1'b0; bus.kill = 1'b0;
    @(negedge clk);
    total++; if (bus.stallReq !== 1'b0) begin bad++; $display("FAIL kill_over_start_stallReq got=%b want=0", bus.stallReq); end
    @(posedge clk); #1;
    run_op(3'd3, 32'd5, 32'd3, 5'd9, res, rdo, lat, ill, sb);
    total++; if (res !== 32'd0) begin bad++; $display("FAIL kill_post_result got=%h want=0", res); end
    total++; if (rdo !== 5'd9) begin bad++; $display("FAIL kill_post_rdOut got=%0d want=9", rdo); end
    total++; if (lat !== 34) begin bad++; $display("FAIL kill_post_latency got=%0d want=34", lat); end
  endtask

  task automatic test_rst_midop();
    logic [31:0] res; logic [4:0] rdo; int lat; logic ill, sb;
    run_op(3'd0, 32'd7, 32'd6, 5'd3, res, rdo, lat, ill, sb);
    total++; if (res !== 32'd42) begin bad++; $display("FAIL rst_pre_result got=%h want=%h", res, 32'd42); end
    bus.startE = 1'b1; bus.funct3E = 3'd1; bus.srcAE = $urandom; bus.srcBE = $urandom; bus.rdE = 5'd21;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c == 10) rst = 1'b1;
    end
    @(posedge clk); #1;
    bus.startE = 1'b0;
    @(negedge clk);
    total++; if (bus.stallReq !== 1'b0) begin bad++; $display("FAIL rst_mid_stallReq got=%b want=0", bus.stallReq); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b want=0", bus.done); end
    total++; if (bus.illegalOp !== 1'b0) begin bad++; $display("FAIL rst_mid_illegalOp got=%b want=0", bus.illegalOp); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL rst_mid_result got=%h want=0", bus.result); end
    total++; if (bus.rdOut !== 5'd0) begin bad++; $display("FAIL rst_mid_rdOut got=%0d want=0", bus.rdOut); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(3'd3, 32'd5, 32'd3, 5'd9, res, rdo, lat, ill, sb);
    total++; if (res !== 32'd0) begin bad++; $display("FAIL rst_post_result got=%h want=0", res); end
    total++; if (rdo !== 5'd9) begin bad++; $display("FAIL rst_post_rdOut got=%0d want=9", rdo); end
    total++; if (lat !== 34) begin bad++; $display("FAIL rst_post_latency got=%0d want=34", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_kill();
    test_rst_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
